// File: rtl/store_buffer_pkg.sv
// Shared RV32 funct3 encodings and the buffered-store entry layout.
package store_buffer_pkg;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry storage for the store buffer: wrapping head/tail pointers
// plus an occupancy count one bit wider than the pointers.
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  output sb_entry_t             head_entry,
  output sb_entry_t             youngest_entry,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         offset;
  logic [PW-1:0]         youngest_idx;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    offset = '0;
    valid  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - head_q;
      valid[i] = {1'b0, offset} < count_q;
    end
  end

  always_comb begin
    youngest_idx   = tail_q - PW'(1);
    head_entry     = mem_q[head_q];
    youngest_entry = mem_q[youngest_idx];
    entries        = mem_q;
    full           = (count_q == CW'(DEPTH));
    empty          = (count_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues aligned stores, drains them when the port is
// free, stalls hazarding loads. Define STORE_BUFFER_FWD_EN for SW->LW forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic        iReqWrite,
  input  logic [31:0] iReqAddr,
  input  logic [31:0] iReqData,
  input  logic [2:0]  iReqFunct3,
  output logic        oRspValid,
  output logic [31:0] oRspData,
  output logic        oFault,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWriteData,
  output logic [2:0]  oMemFunct3,
  output logic        oMemWrite,
  output logic        oMemRead,
  input  logic [31:0] iMemReadData,
  output logic        oEmpty
);

  sb_entry_t             push_entry;
  sb_entry_t             head_entry;
  sb_entry_t             youngest_entry;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic                  full, empty;
  logic                  push, drain, accept;
  logic                  misaligned, bad_funct3, fault_req;
  logic                  hazard, fwd_hit;
  logic                  is_load, load_mem, load_fwd;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  fault_q, fault_d;
  logic [31:0]           rsp_data_q, rsp_data_d;
  logic                  unused_entry_bits;

  store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk            (iClk),
    .rst_n          (iRstN),
    .push           (push),
    .push_entry     (push_entry),
    .pop            (drain),
    .head_entry     (head_entry),
    .youngest_entry (youngest_entry),
    .entries        (entries),
    .valid          (valid),
    .full           (full),
    .empty          (empty)
  );

  assign unused_entry_bits = ^{entries, youngest_entry};

  always_comb begin
    misaligned = 1'b0;
    bad_funct3 = 1'b0;
    if (iReqWrite) begin
      case (iReqFunct3)
        SB:      misaligned = 1'b0;
        SH:      misaligned = iReqAddr[0];
        SW:      misaligned = |iReqAddr[1:0];
        default: bad_funct3 = 1'b1;
      endcase
    end else begin
      case (iReqFunct3)
        LB, LBU: misaligned = 1'b0;
        LH, LHU: misaligned = iReqAddr[0];
        LW:      misaligned = |iReqAddr[1:0];
        default: bad_funct3 = 1'b1;
      endcase
    end
    fault_req = misaligned || bad_funct3;
  end

  // Word-granular (addr[11:2]) match against every live entry.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i].addr[11:2] == iReqAddr[11:2])) begin
        hazard = 1'b1;
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_hit = !empty && (iReqFunct3 == LW) && (youngest_entry.funct3 == SW) &&
                   (youngest_entry.addr[31:2] == iReqAddr[31:2]);
`else
  assign fwd_hit = 1'b0;
`endif

  // Loads own the memory port; the head drains only when no load reads.
  always_comb begin
    is_load  = iReqValid && !iReqWrite && !fault_req;
    load_mem = is_load && !hazard;
    load_fwd = is_load && hazard && fwd_hit;
    drain    = !empty && !load_mem;
    if (fault_req) begin
      oReqReady = 1'b1;
    end else if (iReqWrite) begin
      oReqReady = !full || drain;
    end else begin
      oReqReady = !hazard || fwd_hit;
    end
    accept     = iReqValid && oReqReady;
    push       = accept && iReqWrite && !fault_req;
    push_entry = '{addr: iReqAddr, data: iReqData, funct3: iReqFunct3};
  end

  always_comb begin
    oMemAddr      = '0;
    oMemWriteData = '0;
    oMemFunct3    = '0;
    oMemWrite     = 1'b0;
    oMemRead      = 1'b0;
    if (load_mem) begin
      oMemAddr   = iReqAddr;
      oMemFunct3 = iReqFunct3;
      oMemRead   = 1'b1;
    end else if (drain) begin
      oMemAddr      = head_entry.addr;
      oMemWriteData = head_entry.data;
      oMemFunct3    = head_entry.funct3;
      oMemWrite     = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_d = accept && (fault_req || !iReqWrite);
    fault_d     = accept && fault_req;
    rsp_data_d  = rsp_data_q;
    if (accept && fault_req) begin
      rsp_data_d = '0;
    end else if (load_fwd) begin
      rsp_data_d = youngest_entry.data;
    end else if (load_mem) begin
      rsp_data_d = iMemReadData;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign oRspValid = rsp_valid_q;
  assign oFault    = fault_q;
  assign oRspData  = rsp_data_q;
  assign oEmpty    = empty;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, back-to-back stores, load
// priority, hazard stall/forward, faults, byte lanes and async reset.
`timescale 1ns/1ps
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iReqValid;
  logic        oReqReady;
  logic        iReqWrite;
  logic [31:0] iReqAddr;
  logic [31:0] iReqData;
  logic [2:0]  iReqFunct3;
  logic        oRspValid;
  logic [31:0] oRspData;
  logic        oFault;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWriteData;
  logic [2:0]  oMemFunct3;
  logic        oMemWrite;
  logic        oMemRead;
  logic [31:0] iMemReadData;
  logic        oEmpty;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];
  logic [31:0] wr_log [$];
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr, cap_data;
  logic [2:0]  cap_f3;

  logic        f_w [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] f_a [6] = '{32'h22, 32'h21, 32'h0, 32'h0, 32'h1, 32'h2};
  logic [2:0]  f_f [6] = '{LW, SH, 3'b011, 3'b110, LH, SW};

  store_buffer #(.DEPTH(4)) dut (
    .iClk          (iClk),
    .iRstN         (iRstN),
    .iReqValid     (iReqValid),
    .oReqReady     (oReqReady),
    .iReqWrite     (iReqWrite),
    .iReqAddr      (iReqAddr),
    .iReqData      (iReqData),
    .iReqFunct3    (iReqFunct3),
    .oRspValid     (oRspValid),
    .oRspData      (oRspData),
    .oFault        (oFault),
    .oMemAddr      (oMemAddr),
    .oMemWriteData (oMemWriteData),
    .oMemFunct3    (oMemFunct3),
    .oMemWrite     (oMemWrite),
    .oMemRead      (oMemRead),
    .iMemReadData  (iMemReadData),
    .oEmpty        (oEmpty)
  );

  always #5 iClk = ~iClk;

  assign iMemReadData = mem[oMemAddr[9:2]];

  always @(negedge iClk) begin
    cap_we   = oMemWrite;
    cap_addr = oMemAddr;
    cap_data = oMemWriteData;
    cap_f3   = oMemFunct3;
  end

  always @(posedge iClk) begin
    if (cap_we) begin
      case (cap_f3)
        SB:      mem[cap_addr[9:2]][{cap_addr[1:0], 3'b000} +: 8] = cap_data[7:0];
        SH:      mem[cap_addr[9:2]][{cap_addr[1], 4'b0000} +: 16] = cap_data[15:0];
        default: mem[cap_addr[9:2]] = cap_data;
      endcase
      wr_log.push_back(cap_addr);
    end
  end

  task automatic idle();
    iReqValid = 1'b0; iReqWrite = 1'b0; iReqAddr = '0; iReqData = '0; iReqFunct3 = '0;
    #1;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    iReqValid = 1'b1; iReqWrite = w; iReqAddr = a; iReqData = d; iReqFunct3 = f3;
    #1;
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    idle();
    total++; if (oEmpty !== 1'b1)      begin bad++; $display("[TB] FAIL rst_empty got=%0b exp=1", oEmpty); end
    total++; if (oRspValid !== 1'b0)   begin bad++; $display("[TB] FAIL rst_rspvalid got=%0b exp=0", oRspValid); end
    total++; if (oFault !== 1'b0)      begin bad++; $display("[TB] FAIL rst_fault got=%0b exp=0", oFault); end
    total++; if (oRspData !== 32'h0)   begin bad++; $display("[TB] FAIL rst_rspdata got=%h exp=0", oRspData); end
    total++; if (oMemWrite !== 1'b0)   begin bad++; $display("[TB] FAIL rst_memwrite got=%0b exp=0", oMemWrite); end
    total++; if (oMemRead !== 1'b0)    begin bad++; $display("[TB] FAIL rst_memread got=%0b exp=0", oMemRead); end
    step();
    step();
    iRstN = 1'b1;
    #1;
  endtask

  task automatic test_drain_order();
    wr_log.delete();
    drive(1'b1, 32'h10, 32'h11111111, SW);
    total++; if (oReqReady !== 1'b1) begin bad++; $display("[TB] FAIL order_rdy got=%0b exp=1", oReqReady); end
    total++; if (oMemWrite !== 1'b0) begin bad++; $display("[TB] FAIL order_nowrite got=%0b exp=0", oMemWrite); end
    step();
    drive(1'b1, 32'h14, 32'h22222222, SW);
    total++; if ({oMemWrite, oMemAddr, oMemWriteData} !== {1'b1, 32'h10, 32'h11111111})
      begin bad++; $display("[TB] FAIL order_d0 got=%0b/%h/%h exp=1/10/11111111", oMemWrite, oMemAddr, oMemWriteData); end
    total++; if (oRspValid !== 1'b0) begin bad++; $display("[TB] FAIL order_norsp got=%0b exp=0", oRspValid); end
    step();
    drive(1'b1, 32'h18, 32'h33333333, SW);
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h14}) begin bad++; $display("[TB] FAIL order_d1 got=%0b/%h exp=1/14", oMemWrite, oMemAddr); end
    step();
    idle();
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h18}) begin bad++; $display("[TB] FAIL order_d2 got=%0b/%h exp=1/18", oMemWrite, oMemAddr); end
    step();
    total++; if (oEmpty !== 1'b1) begin bad++; $display("[TB] FAIL order_empty got=%0b exp=1", oEmpty); end
    total++; if ({oMemWrite, oMemAddr, oMemRead} !== {1'b0, 32'h0, 1'b0}) begin bad++; $display("[TB] FAIL order_idle got=%0b/%h/%0b exp=0/0/0", oMemWrite, oMemAddr, oMemRead); end
    total++; if (wr_log.size() != 3 || wr_log[0] !== 32'h10 || wr_log[1] !== 32'h14 || wr_log[2] !== 32'h18)
      begin bad++; $display("[TB] FAIL order_log got size=%0d exp=3 in order 10,14,18", wr_log.size()); end
    total++; if (mem[6] !== 32'h33333333) begin bad++; $display("[TB] FAIL order_mem got=%h exp=33333333", mem[6]); end
  endtask

  task automatic test_back_to_back();
    wr_log.delete();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), SW);
      total++; if (oReqReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_rdy%0d got=%0b exp=1", k, oReqReady); end
      if (k > 0) begin
        total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h100 + 32'(4 * (k - 1))})
          begin bad++; $display("[TB] FAIL b2b_drain%0d got=%0b/%h exp=1/%h", k, oMemWrite, oMemAddr, 32'h100 + 32'(4 * (k - 1))); end
      end
      step();
    end
    idle();
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h110}) begin bad++; $display("[TB] FAIL b2b_last got=%0b/%h exp=1/110", oMemWrite, oMemAddr); end
    step();
    total++; if (oEmpty !== 1'b1) begin bad++; $display("[TB] FAIL b2b_empty got=%0b exp=1", oEmpty); end
    for (int i = 0; i < 5; i++) begin
      total++; if (wr_log.size() <= i || wr_log[i] !== 32'h100 + 32'(4 * i))
        begin bad++; $display("[TB] FAIL b2b_log%0d size=%0d exp addr=%h", i, wr_log.size(), 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 32'h30, 32'h30303030, SW);
    step();
    drive(1'b0, 32'h44, 32'h0, LW);
    total++; if (oReqReady !== 1'b1) begin bad++; $display("[TB] FAIL prio_rdy got=%0b exp=1", oReqReady); end
    total++; if ({oMemRead, oMemWrite, oMemAddr} !== {1'b1, 1'b0, 32'h44})
      begin bad++; $display("[TB] FAIL prio_port got=%0b/%0b/%h exp=1/0/44", oMemRead, oMemWrite, oMemAddr); end
    total++; if (oEmpty !== 1'b0) begin bad++; $display("[TB] FAIL prio_held got=%0b exp=0", oEmpty); end
    step();
    idle();
    total++; if ({oRspValid, oFault, oRspData} !== {1'b1, 1'b0, 32'hC0FFEE11})
      begin bad++; $display("[TB] FAIL prio_rsp got=%0b/%0b/%h exp=1/0/c0ffee11", oRspValid, oFault, oRspData); end
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h30}) begin bad++; $display("[TB] FAIL prio_drain got=%0b/%h exp=1/30", oMemWrite, oMemAddr); end
    step();
    total++; if ({oRspValid, oEmpty} !== 2'b01) begin bad++; $display("[TB] FAIL prio_after got=%0b/%0b exp=0/1", oRspValid, oEmpty); end
  endtask

  task automatic test_hazard();
    drive(1'b1, 32'h20, 32'hDEADBEEF, SW);
    step();
    drive(1'b0, 32'h20, 32'h0, LW);
`ifdef STORE_BUFFER_FWD_EN
    total++; if ({oReqReady, oMemRead} !== 2'b10) begin bad++; $display("[TB] FAIL fwd_accept got=%0b/%0b exp=1/0", oReqReady, oMemRead); end
    step();
    idle();
    total++; if ({oRspValid, oFault, oRspData} !== {1'b1, 1'b0, 32'hDEADBEEF})
      begin bad++; $display("[TB] FAIL fwd_rsp got=%0b/%0b/%h exp=1/0/deadbeef", oRspValid, oFault, oRspData); end
`else
    total++; if ({oReqReady, oMemRead} !== 2'b00) begin bad++; $display("[TB] FAIL haz_stall got=%0b/%0b exp=0/0", oReqReady, oMemRead); end
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h20}) begin bad++; $display("[TB] FAIL haz_drain got=%0b/%h exp=1/20", oMemWrite, oMemAddr); end
    step();
    total++; if ({oReqReady, oMemRead, oMemWrite, oMemAddr} !== {1'b1, 1'b1, 1'b0, 32'h20})
      begin bad++; $display("[TB] FAIL haz_read got=%0b/%0b/%0b/%h exp=1/1/0/20", oReqReady, oMemRead, oMemWrite, oMemAddr); end
    step();
    idle();
    total++; if ({oRspValid, oFault, oRspData} !== {1'b1, 1'b0, 32'hDEADBEEF})
      begin bad++; $display("[TB] FAIL haz_rsp got=%0b/%0b/%h exp=1/0/deadbeef", oRspValid, oFault, oRspData); end
`endif
    step();
    total++; if ({oRspValid, oEmpty} !== 2'b01) begin bad++; $display("[TB] FAIL haz_pulse got=%0b/%0b exp=0/1", oRspValid, oEmpty); end
  endtask

  task automatic test_fault();
    wr_log.delete();
    for (int i = 0; i < 6; i++) begin
      drive(f_w[i], f_a[i], 32'h5A5A5A5A, f_f[i]);
      total++; if ({oReqReady, oMemRead, oMemWrite} !== 3'b100)
        begin bad++; $display("[TB] FAIL fault%0d_accept got=%0b/%0b/%0b exp=1/0/0", i, oReqReady, oMemRead, oMemWrite); end
      step();
      idle();
      total++; if ({oRspValid, oFault, oRspData, oEmpty} !== {1'b1, 1'b1, 32'h0, 1'b1})
        begin bad++; $display("[TB] FAIL fault%0d_rsp got=%0b/%0b/%h/%0b exp=1/1/0/1", i, oRspValid, oFault, oRspData, oEmpty); end
    end
    step();
    total++; if (wr_log.size() != 0) begin bad++; $display("[TB] FAIL fault_nowrite got=%0d exp=0", wr_log.size()); end
    total++; if (mem[8] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL fault_mem got=%h exp=deadbeef", mem[8]); end
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, 32'h61, 32'h000000AB, SB);
    step();
    drive(1'b1, 32'h62, 32'h00001234, SH);
    total++; if ({oMemWrite, oMemFunct3, oMemAddr, oMemWriteData} !== {1'b1, SB, 32'h61, 32'hAB})
      begin bad++; $display("[TB] FAIL sb_drain got=%0b/%0d/%h/%h exp=1/0/61/ab", oMemWrite, oMemFunct3, oMemAddr, oMemWriteData); end
    step();
    idle();
    total++; if ({oMemWrite, oMemFunct3, oMemAddr} !== {1'b1, SH, 32'h62})
      begin bad++; $display("[TB] FAIL sh_drain got=%0b/%0d/%h exp=1/1/62", oMemWrite, oMemFunct3, oMemAddr); end
    step();
    total++; if (mem[24] !== 32'h1234AB18) begin bad++; $display("[TB] FAIL lanes_mem got=%h exp=1234ab18", mem[24]); end
  endtask

  task automatic test_reset_mid();
    wr_log.delete();
    drive(1'b1, 32'h50, 32'h55555555, SW);
    step();
    drive(1'b1, 32'h54, 32'h66666666, SW);
    step();
    idle();
    total++; if ({oMemWrite, oMemAddr} !== {1'b1, 32'h54}) begin bad++; $display("[TB] FAIL rmid_pending got=%0b/%h exp=1/54", oMemWrite, oMemAddr); end
    iRstN = 1'b0;
    #1;
    total++; if ({oEmpty, oMemWrite, oRspValid} !== 3'b100)
      begin bad++; $display("[TB] FAIL rmid_async got=%0b/%0b/%0b exp=1/0/0", oEmpty, oMemWrite, oRspValid); end
    step();
    step();
    iRstN = 1'b1;
    #1;
    step();
    step();
    total++; if (wr_log.size() != 1 || wr_log[0] !== 32'h50) begin bad++; $display("[TB] FAIL rmid_log got size=%0d exp=1 (addr 50)", wr_log.size()); end
    total++; if (mem[21] !== 32'hC0FFEE15) begin bad++; $display("[TB] FAIL rmid_mem got=%h exp=c0ffee15", mem[21]); end
    total++; if ({oEmpty, oMemWrite} !== 2'b10) begin bad++; $display("[TB] FAIL rmid_after got=%0b/%0b exp=1/0", oEmpty, oMemWrite); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0FFEE00 | 32'(i);
    test_reset();
    test_drain_order();
    test_back_to_back();
    test_load_priority();
    test_hazard();
    test_fault();
    test_byte_lanes();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), meaning the number of store entries.
REQ-002 SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRstN, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have iReqValid/oReqReady, input/output, 1 bit each: pipeline MEM-stage request handshake.
REQ-005 SHALL have iReqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have iReqAddr, iReqData, iReqFunct3, inputs of 32/32/3 bits: byte address, store data, RV32 funct3.
REQ-007 SHALL have oRspValid, oRspData, oFault, outputs of 1/32/1 bits: registered load/fault response.
REQ-008 SHALL have oMemAddr, oMemWriteData, oMemFunct3, oMemWrite, oMemRead, outputs of 32/32/3/1/1 bits, and iMemReadData, input, 32 bits: port to the asynchronous-read, synchronous-write data memory.
REQ-009 SHALL have oEmpty, output, 1 bit: no buffered stores (fence/drain status).

Function
REQ-010 A transfer SHALL occur when iReqValid && oReqReady at a rising edge.
REQ-011 An accepted aligned store (SB any address; SH addr[0]=0; SW addr[1:0]=0) SHALL be enqueued at the tail with addr/data/funct3 and produce no response.
REQ-012 A misaligned access, a store funct3 > 3'b010, or a load funct3 of 3'b011, 3'b110 or 3'b111 SHALL be accepted, not enqueued or read, and give oRspValid=1, oFault=1, oRspData=0 the next cycle.
REQ-013 A store SHALL be refused (oReqReady=0) when the buffer is full, unless the head entry drains in the same cycle, in which case it is accepted and the count is unchanged.
REQ-014 A load SHALL be refused while any valid entry's addr[11:2] equals iReqAddr[11:2] (hazard); otherwise oReqReady=1 for loads.
REQ-015 An accepted hazard-free load SHALL drive oMemRead=1 with oMemAddr/oMemFunct3 from the request that cycle, and register iMemReadData to oRspData with oRspValid=1, oFault=0 one cycle later (latency 1).
REQ-016 When no load uses the port and the buffer is non-empty, the head entry SHALL drive oMemWrite=1 with its addr/data/funct3 and be dequeued at that edge.
REQ-017 Loads SHALL have port priority; the drain stalls during a load cycle. oMemRead and oMemWrite SHALL never both be 1.
REQ-018 oRspValid SHALL be a single-cycle pulse per accepted load or fault; there is no backpressure on the response.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an occupancy count of log2(DEPTH)+1 bits.
REQ-020 Stores SHALL reach memory in acceptance order.
REQ-021 When idle, the oMem* outputs SHALL be 0.

Reset
REQ-022 Asserting iRstN low SHALL immediately clear the count and pointers, discard buffered stores, and set oRspValid=0, oFault=0, oRspData=0, oMemWrite=0, oMemRead=0, and oEmpty=1.
REQ-023 Reset mid-drain SHALL abort the drain with no partial accounting; a write sampled at the same edge as reset assertion is undefined.

Configuration
REQ-024 Macro STORE_BUFFER_FWD_EN: when defined, a hazard load that is LW to a word address matching the youngest entry, where that entry is an SW, SHALL be accepted without a memory read and return that entry's data with latency 1.
REQ-025 All other hazards SHALL still stall when STORE_BUFFER_FWD_EN is defined; without the macro, every hazard stalls per REQ-014.

Structure
REQ-026 Package store_buffer_pkg SHALL hold the funct3 localparams (SB, SH, SW, LB, LH, LW, LBU, LHU) and the entry struct typedef (addr, data, funct3).
REQ-027 Entry storage and pointer/count logic SHALL be sub-module store_buffer_fifo; hazard, alignment and arbitration logic stay in the top.

Verification
REQ-028 Three SW requests to 0x10, 0x14 and 0x18 back-to-back, then idle -> the drains appear on oMemWrite in order over 3 cycles, then oEmpty=1.
REQ-029 DEPTH=4: five stores with no loads -> the fifth is accepted on the cycle the head drains, and oReqReady never drops while draining.
REQ-030 SW 0xDEADBEEF to 0x20 buffered, then LW 0x20 -> without the macro the load stalls until drained and returns 0xDEADBEEF; with STORE_BUFFER_FWD_EN it returns 0xDEADBEEF next cycle with oMemRead=0.
REQ-031 LW 0x22 or SH 0x21 -> oFault=1 next cycle, memory untouched, buffer count unchanged.
REQ-032 Two stores buffered, then iRstN pulsed low -> oEmpty=1 immediately and no further oMemWrite.
